mcu_sequencer: RTL and testbench
================================

Name: mcu_sequencer

Overview:
- Upstream instruction-issue stage for the mcu datapath.
- Holds a small program memory of encoded instructions (op, op0, op1, op2) and issues them one per clock to the mcu after a start pulse.
- Samples mcu op_err in the issue cycle and halts on an illegal opcode.
- Captures mcu out for every read instruction and presents it on a valid-qualified result port.

Parameters:
- op_sz, 6, data width; width of op1 and of mcu out.
- mem_sz, 5, mcu address width; width of op0 and op2.
- pc_sz, 4, program-memory address width; depth = 2^pc_sz entries.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- load_en  in  1  write one program entry this cycle. Honoured only when busy=0.
- load_addr  in  pc_sz  program entry index.
- load_data  in  4+mem_sz+op_sz+mem_sz  instruction = {op, op0, op1, op2}, op in the MSBs.
- prog_len  in  pc_sz+1  number of instructions to run; sampled on start.
- start  in  1  single-cycle run request. Ignored when busy=1.
- abort  in  1  synchronous run cancel.
- op  out  4  opcode to the mcu.
- op0  out  mem_sz  to the mcu.
- op1  out  op_sz  to the mcu.
- op2  out  mem_sz  to the mcu.
- mcu_out  in  op_sz  mcu out. Valid the cycle after a read is issued.
- mcu_op_err  in  1  mcu op_err. Combinational from op.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse at the end of a clean run.
- err  out  1  level; high while in ERROR.
- err_pc  out  pc_sz  index of the offending instruction.
- rd_valid  out  1  one-cycle pulse; rd_data is valid.
- rd_data  out  op_sz  captured read result.

Behaviour:
- Reset (asynchronous) values:
  - State IDLE; pc=0.
  - busy, done, err, rd_valid = 0; err_pc=0; rd_data=0; read-pending flag=0.
  - Program memory is not cleared.
- Outside RUN the mcu ports carry NOP: op=7 (read), op0=op1=op2=0. NOP never raises op_err.
- States:
  - IDLE:
    - start with prog_len=0 -> DRAIN.
    - start with prog_len>0 -> RUN, pc=0.
    - Length register = min(prog_len, 2^pc_sz).
  - RUN:
    - op/op0/op1/op2 are driven combinationally from prog_mem[pc].
    - If mcu_op_err=1 this cycle -> ERROR, err_pc<=pc. The instruction is not counted as a read.
    - Else if pc==len-1 -> DRAIN.
    - Otherwise pc<=pc+1 (wraps at 2^pc_sz; a 16-entry run issues indices 0..15 exactly once).
  - DRAIN: one cycle, NOP on ports -> IDLE with done=1 for one cycle.
  - ERROR:
    - err=1 and err_pc held; NOP on ports.
    - start -> clears err, then behaves as the IDLE start rules.
    - abort -> IDLE, err=0.
- Read capture:
  - A read (op=7) issued in RUN in cycle N sets the pending flag at the end of N.
  - At the end of N+1: rd_data<=mcu_out, rd_valid=1 during N+2.
  - Back-to-back reads therefore give back-to-back rd_valid pulses.
- Timing for a clean run of length L, start sampled at edge 0:
  - Instruction i is on the ports in cycle i+1.
  - DRAIN is cycle L+1.
  - done is high in cycle L+2, coincident with rd_valid of a final read.
- Error during a run: a read issued before the faulting instruction still produces its rd_valid.
- abort (any state):
  - Next state IDLE; pending read cleared; no done.
  - abort has priority over start and over error detection in the same cycle.
- Simultaneous start and load_en in IDLE: the load is written first; the run uses the new entry.

Decomposition:
- Package mcu_pkg:
  - Opcode constants OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3, OP_AND=4, OP_OR=5, OP_XOR=6, OP_READ=7, OP_WRITE=8, OP_NOP=OP_READ.
  - Instruction field offsets and widths.
  - Sequencer state encoding.
- Sub-module seq_prog_mem: 2^pc_sz x instruction-width register array, one synchronous write port, one combinational read port.

Test Plan:
- Reset mid-run (asserted in cycle 3 of a 4-instruction run) -> immediately idle: busy=0, op=7, op0=op1=op2=0, no done, no rd_valid.
- Load {8,0,9,0},{8,1,3,0},{0,0,1,3},{7,3,0,0}, prog_len=4, start with the mcu attached:
  - ops 8,8,0,7 appear in cycles 1-4.
  - rd_valid and rd_data=12 in cycle 6; done in cycle 6.
- Entry 2 replaced by op=9, prog_len=4:
  - err=1 and err_pc=2 from cycle 4; entry 3 never issued; done never pulses.
  - A subsequent clean start clears err.
- prog_len=0 start -> no instruction issued, done in cycle 2. prog_len=20 with 16 entries loaded -> exactly 16 issues, indices 0..15, then done.
- abort in cycle 3 of the 4-instruction run -> IDLE next cycle, no rd_valid, no done.
  - start and load_en asserted while busy are ignored: pc and memory contents unchanged.
- Program of reads at addresses 0,1,2 back-to-back -> three consecutive rd_valid pulses (cycles 3,4,5) carrying mem[0..2] in order.

Source files
------------

// File: rtl/mcu_pkg.sv
// mcu_pkg: opcodes, instruction layout helpers and sequencer state
// encoding shared by the mcu issue-stage files.
package mcu_pkg;

  localparam int OPC_W = 4;

  localparam logic [OPC_W-1:0] OP_ADD   = 4'd0;
  localparam logic [OPC_W-1:0] OP_SUB   = 4'd1;
  localparam logic [OPC_W-1:0] OP_MUL   = 4'd2;
  localparam logic [OPC_W-1:0] OP_DIV   = 4'd3;
  localparam logic [OPC_W-1:0] OP_AND   = 4'd4;
  localparam logic [OPC_W-1:0] OP_OR    = 4'd5;
  localparam logic [OPC_W-1:0] OP_XOR   = 4'd6;
  localparam logic [OPC_W-1:0] OP_READ  = 4'd7;
  localparam logic [OPC_W-1:0] OP_WRITE = 4'd8;
  localparam logic [OPC_W-1:0] OP_NOP   = OP_READ;

  localparam int DEF_OP_SZ  = 6;
  localparam int DEF_MEM_SZ = 5;
  localparam int DEF_PC_SZ  = 4;

  // Instruction = {op, op0, op1, op2}, op in the MSBs.
  function automatic int instr_w(int op_sz, int mem_sz);
    return OPC_W + 2 * mem_sz + op_sz;
  endfunction

  function automatic int f_op2_lsb();
    return 0;
  endfunction

  function automatic int f_op1_lsb(int mem_sz);
    return mem_sz;
  endfunction

  function automatic int f_op0_lsb(int op_sz, int mem_sz);
    return mem_sz + op_sz;
  endfunction

  function automatic int f_opc_lsb(int op_sz, int mem_sz);
    return 2 * mem_sz + op_sz;
  endfunction

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_ERROR
  } seq_state_e;

endpackage

// File: rtl/seq_prog_mem.sv
// seq_prog_mem: 2^aw x dw program store.
// Ports: clk, we/waddr/wdata sync write; raddr/rdata comb read.
module seq_prog_mem #(
  parameter int aw = 4,
  parameter int dw = 20
) (
  input  logic          clk,
  input  logic          we,
  input  logic [aw-1:0] waddr,
  input  logic [dw-1:0] wdata,
  input  logic [aw-1:0] raddr,
  output logic [dw-1:0] rdata
);

  logic [dw-1:0] mem [2**aw];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mcu_sequencer.sv
// mcu_sequencer: issues program entries to the mcu one per clock.
// Ports: load_* write, start/abort/prog_len run ctrl, op* to mcu,
// mcu_out/mcu_op_err from mcu, busy/done/err/err_pc/rd_* status.
module mcu_sequencer
  import mcu_pkg::*;
#(
  parameter int op_sz  = DEF_OP_SZ,
  parameter int mem_sz = DEF_MEM_SZ,
  parameter int pc_sz  = DEF_PC_SZ
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              load_en,
  input  logic [pc_sz-1:0]                  load_addr,
  input  logic [OPC_W+2*mem_sz+op_sz-1:0]   load_data,
  input  logic [pc_sz:0]                    prog_len,
  input  logic                              start,
  input  logic                              abort,
  output logic [OPC_W-1:0]                  op,
  output logic [mem_sz-1:0]                 op0,
  output logic [op_sz-1:0]                  op1,
  output logic [mem_sz-1:0]                 op2,
  input  logic [op_sz-1:0]                  mcu_out,
  input  logic                              mcu_op_err,
  output logic                              busy,
  output logic                              done,
  output logic                              err,
  output logic [pc_sz-1:0]                  err_pc,
  output logic                              rd_valid,
  output logic [op_sz-1:0]                  rd_data
);

  localparam int IW    = instr_w(op_sz, mem_sz);
  localparam int LW    = pc_sz + 1;
  localparam int DEPTH = 1 << pc_sz;
  localparam int O2    = f_op2_lsb();
  localparam int O1    = f_op1_lsb(mem_sz);
  localparam int O0    = f_op0_lsb(op_sz, mem_sz);
  localparam int OC    = f_opc_lsb(op_sz, mem_sz);

  seq_state_e       state_q, state_d;
  logic [pc_sz-1:0] pc_q, pc_d;
  logic [LW-1:0]    len_q, len_d;
  logic [LW-1:0]    len_clip;
  logic [pc_sz-1:0] err_pc_d;
  logic             done_d;
  logic             pend_q, pend_d;
  logic             run;
  logic             last;
  logic             cap;
  logic [IW-1:0]    instr;

  assign run  = (state_q == S_RUN);
  assign busy = run || (state_q == S_DRAIN);
  assign err  = (state_q == S_ERROR);

  seq_prog_mem #(
    .aw (pc_sz),
    .dw (IW)
  ) u_mem (
    .clk   (clk),
    .we    (load_en && !busy),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (pc_q),
    .rdata (instr)
  );

  always_comb begin
    op  = OP_NOP;
    op0 = '0;
    op1 = '0;
    op2 = '0;
    if (run) begin
      op  = instr[OC +: OPC_W];
      op0 = instr[O0 +: mem_sz];
      op1 = instr[O1 +: op_sz];
      op2 = instr[O2 +: mem_sz];
    end
  end

  // Runs longer than the memory are clipped so each entry issues once.
  assign len_clip = (prog_len > LW'(DEPTH)) ? LW'(DEPTH) : prog_len;
  assign last     = ({1'b0, pc_q} == (len_q - LW'(1)));

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    len_d    = len_q;
    err_pc_d = err_pc;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE, S_ERROR: begin
        if (start) begin
          len_d   = len_clip;
          pc_d    = '0;
          state_d = (prog_len == '0) ? S_DRAIN : S_RUN;
        end
      end
      S_RUN: begin
        if (mcu_op_err) begin
          state_d  = S_ERROR;
          err_pc_d = pc_q;
        end else if (last) begin
          state_d = S_DRAIN;
        end else begin
          pc_d = pc_q + pc_sz'(1);
        end
      end
      S_DRAIN: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    // Abort beats start and error capture in the same cycle.
    if (abort) begin
      state_d  = S_IDLE;
      err_pc_d = err_pc;
      done_d   = 1'b0;
    end
  end

  assign pend_d = run && (op == OP_READ) && !mcu_op_err && !abort;
  assign cap    = pend_q && !abort;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      len_q    <= '0;
      err_pc   <= '0;
      done     <= 1'b0;
      pend_q   <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      len_q    <= len_d;
      err_pc   <= err_pc_d;
      done     <= done_d;
      pend_q   <= pend_d;
      rd_valid <= cap;
      if (cap) rd_data <= mcu_out;
    end
  end

endmodule

// File: tb/tb_mcu_sequencer.sv
// tb_mcu_sequencer: directed checks of the issue FSM against a
// small behavioural mcu (write/add/read, op_err for op > 8).
module tb_mcu_sequencer;

  logic        clk;
  logic        reset;
  logic        load_en;
  logic [3:0]  load_addr;
  logic [19:0] load_data;
  logic [4:0]  prog_len;
  logic        start;
  logic        abort;
  logic [3:0]  op;
  logic [4:0]  op0;
  logic [5:0]  op1;
  logic [4:0]  op2;
  logic [5:0]  mcu_out;
  logic        mcu_op_err;
  logic        busy;
  logic        done;
  logic        err;
  logic [3:0]  err_pc;
  logic        rd_valid;
  logic [5:0]  rd_data;

  int n_chk;
  int n_fail;

  mcu_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .prog_len   (prog_len),
    .start      (start),
    .abort      (abort),
    .op         (op),
    .op0        (op0),
    .op1        (op1),
    .op2        (op2),
    .mcu_out    (mcu_out),
    .mcu_op_err (mcu_op_err),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_pc     (err_pc),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural mcu: out registered one cycle after a read.
  logic [5:0] mmem [32];
  assign mcu_op_err = (op > 4'd8);
  always @(posedge clk) begin
    case (op)
      4'd0: mmem[op2] <= mmem[op0] + mmem[op1[4:0]];
      4'd1: mmem[op2] <= mmem[op0] - mmem[op1[4:0]];
      4'd7: mcu_out <= mmem[op0];
      4'd8: mmem[op0] <= op1;
      default: ;
    endcase
  end

  function automatic logic [19:0] enc(input logic [3:0] o,
                                      input logic [4:0] a,
                                      input logic [5:0] d,
                                      input logic [4:0] b);
    return {o, a, d, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [3:0] a, input logic [19:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en   = 1'b0;
  endtask

  task automatic go(input logic [4:0] len);
    prog_len = len;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    reset     = 1'b1;
    load_en   = 1'b0;
    load_addr = '0;
    load_data = '0;
    prog_len  = '0;
    start     = 1'b0;
    abort     = 1'b0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_errpc", 32'(err_pc), 32'd0);
    chk("rst_rdv", 32'(rd_valid), 32'd0);
    chk("rst_rdd", 32'(rd_data), 32'd0);
    chk("rst_op", 32'(op), 32'd7);
    chk("rst_ops", 32'({op0, op1, op2}), 32'd0);
    reset = 1'b0;
    tick();

    load(4'd0, enc(4'd8, 5'd0, 6'd9, 5'd0));
    load(4'd1, enc(4'd8, 5'd1, 6'd3, 5'd0));
    load(4'd2, enc(4'd0, 5'd0, 6'd1, 5'd3));
    load(4'd3, enc(4'd7, 5'd3, 6'd0, 5'd0));

    // Reset asserted in cycle 3 of a run.
    go(5'd4);
    chk("mr_c1_busy", 32'(busy), 32'd1);
    chk("mr_c1_op", 32'(op), 32'd8);
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_op", 32'(op), 32'd7);
    chk("mr_ops", 32'({op0, op1, op2}), 32'd0);
    chk("mr_done", 32'(done), 32'd0);
    chk("mr_rdv", 32'(rd_valid), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("mr_post_done", 32'(done), 32'd0);

    // Clean 4-instruction run.
    go(5'd4);
    chk("run_c1_op", 32'(op), 32'd8);
    chk("run_c1_op1", 32'(op1), 32'd9);
    tick();
    chk("run_c2_op", 32'(op), 32'd8);
    chk("run_c2_op0", 32'(op0), 32'd1);
    tick();
    chk("run_c3_op", 32'(op), 32'd0);
    chk("run_c3_op2", 32'(op2), 32'd3);
    tick();
    chk("run_c4_op", 32'(op), 32'd7);
    chk("run_c4_op0", 32'(op0), 32'd3);
    tick();
    chk("run_c5_busy", 32'(busy), 32'd1);
    chk("run_c5_nop", 32'({op, op0, op1, op2}), 32'h70000);
    chk("run_c5_done", 32'(done), 32'd0);
    chk("run_c5_rdv", 32'(rd_valid), 32'd0);
    tick();
    chk("run_c6_rdv", 32'(rd_valid), 32'd1);
    chk("run_c6_rdd", 32'(rd_data), 32'd12);
    chk("run_c6_done", 32'(done), 32'd1);
    chk("run_c6_busy", 32'(busy), 32'd0);
    tick();
    chk("run_c7_done", 32'(done), 32'd0);
    chk("run_c7_rdv", 32'(rd_valid), 32'd0);

    // Illegal opcode at entry 2.
    load(4'd2, enc(4'd9, 5'd0, 6'd0, 5'd0));
    go(5'd4);
    tick();
    tick();
    chk("er_c3_op", 32'(op), 32'd9);
    tick();
    chk("er_c4_err", 32'(err), 32'd1);
    chk("er_c4_pc", 32'(err_pc), 32'd2);
    chk("er_c4_busy", 32'(busy), 32'd0);
    chk("er_c4_op", 32'(op), 32'd7);
    chk("er_c4_done", 32'(done), 32'd0);
    tick();
    chk("er_c5_err", 32'(err), 32'd1);
    chk("er_c5_done", 32'(done), 32'd0);
    go(5'd2);
    chk("er_rs_err", 32'(err), 32'd0);
    chk("er_rs_busy", 32'(busy), 32'd1);
    tick();
    tick();
    tick();
    chk("er_rs_done", 32'(done), 32'd1);

    // Zero-length run.
    go(5'd0);
    chk("z_c1_busy", 32'(busy), 32'd1);
    chk("z_c1_op", 32'(op), 32'd7);
    tick();
    chk("z_c2_done", 32'(done), 32'd1);
    chk("z_c2_busy", 32'(busy), 32'd0);

    // Abort in cycle 3, with start and load also asserted.
    load(4'd2, enc(4'd0, 5'd0, 6'd1, 5'd3));
    go(5'd4);
    tick();
    tick();
    abort     = 1'b1;
    start     = 1'b1;
    load_en   = 1'b1;
    load_addr = 4'd0;
    load_data = enc(4'd9, 5'd0, 6'd0, 5'd0);
    tick();
    abort   = 1'b0;
    start   = 1'b0;
    load_en = 1'b0;
    chk("ab_c4_busy", 32'(busy), 32'd0);
    chk("ab_c4_op", 32'(op), 32'd7);
    tick();
    chk("ab_c5_rdv", 32'(rd_valid), 32'd0);
    chk("ab_c5_done", 32'(done), 32'd0);
    tick();
    chk("ab_c6_rdv", 32'(rd_valid), 32'd0);
    chk("ab_c6_done", 32'(done), 32'd0);

    // start/load while busy are ignored.
    go(5'd4);
    chk("bz_c1_op", 32'(op), 32'd8);
    start     = 1'b1;
    load_en   = 1'b1;
    load_addr = 4'd3;
    load_data = enc(4'd8, 5'd5, 6'd1, 5'd0);
    tick();
    start   = 1'b0;
    load_en = 1'b0;
    tick();
    chk("bz_c3_op", 32'(op), 32'd0);
    tick();
    chk("bz_c4_op", 32'(op), 32'd7);
    chk("bz_c4_op0", 32'(op0), 32'd3);
    tick();
    tick();
    chk("bz_c6_done", 32'(done), 32'd1);
    chk("bz_c6_rdd", 32'(rd_data), 32'd12);

    // Full memory, prog_len above depth.
    for (int i = 0; i < 16; i++)
      load(4'(i), enc(4'd8, 5'(i), 6'(i + 1), 5'd0));
    go(5'd20);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("full_op1_%0d", i), 32'(op1), 32'(i + 1));
      chk($sformatf("full_op_%0d", i), 32'(op), 32'd8);
      tick();
    end
    chk("full_drain_busy", 32'(busy), 32'd1);
    chk("full_drain_op1", 32'(op1), 32'd0);
    chk("full_drain_done", 32'(done), 32'd0);
    tick();
    chk("full_done", 32'(done), 32'd1);

    // Back-to-back reads of mcu addresses 0..2.
    for (int i = 0; i < 3; i++)
      load(4'(i), enc(4'd7, 5'(i), 6'd0, 5'd0));
    go(5'd3);
    chk("rd_c1_op", 32'(op), 32'd7);
    tick();
    chk("rd_c2_rdv", 32'(rd_valid), 32'd0);
    tick();
    chk("rd_c3_rdv", 32'(rd_valid), 32'd1);
    chk("rd_c3_rdd", 32'(rd_data), 32'd1);
    tick();
    chk("rd_c4_rdv", 32'(rd_valid), 32'd1);
    chk("rd_c4_rdd", 32'(rd_data), 32'd2);
    tick();
    chk("rd_c5_rdv", 32'(rd_valid), 32'd1);
    chk("rd_c5_rdd", 32'(rd_data), 32'd3);
    chk("rd_c5_done", 32'(done), 32'd1);
    tick();
    chk("rd_c6_rdv", 32'(rd_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
